// File: rtl/adc_capture_csr.sv
// Multi-channel ADC capture buffer with a trigger FSM and a Wishbone register/readback port.
// Optional define ADC_CAP_OFFSET_SUB_EN: per-channel offset subtraction on the sample write path.
module adc_capture_csr #(
  parameter int G_NCHAN      = 2,
  parameter int G_DEPTH_LOG2 = 12,
  parameter int G_DATA_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [G_DEPTH_LOG2+5:2]     wb_adr_i,
  input  logic [3:0]                  wb_sel_i,
  input  logic [31:0]                 wb_dat_i,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic                        wb_rty_o,
  output logic                        wb_stall_o,
  output logic [31:0]                 wb_dat_o,
  input  logic [31:0]                 version_i,
  input  logic [G_NCHAN*G_DATA_W-1:0] adc_data_i,
  input  logic                        adc_valid_i,
  input  logic                        trig_i,
  output logic                        irq_o
);
  localparam int AW = G_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_MAX = '1;
  localparam logic [AW+2:0] IDX_VERSION = (AW+3)'(32'd0);
  localparam logic [AW+2:0] IDX_CTRL    = (AW+3)'(32'd1);
  localparam logic [AW+2:0] IDX_STATUS  = (AW+3)'(32'd2);
  localparam logic [AW+2:0] IDX_POSTLEN = (AW+3)'(32'd3);
  localparam logic [AW+2:0] IDX_OFS0    = (AW+3)'(32'd8);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel_v);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel_v[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  cap_state_t                  state_r, state_nx_s;
  logic [AW-1:0]               wr_ptr_r, trig_ptr_r, postlen_r;
  logic [AW:0]                 post_cnt_r, cnt_nx_s, postlen_eff_s;
  logic                        wrapped_r, trig_prev_r, irq_r;
  logic                        ack_r, busy_r;
  logic [31:0]                 dat_r, reg_rdata_s, ofs_rdata_s;
  logic [2:0]                  rd_chan_r;
  logic                        buf_sel_s, req_s, buf_rd_s, reg_wr_s, ctrl_wr_s;
  logic                        arm_s, abort_s, force_s, trig_s, wr_en_s, trig_src_s;
  logic [2:0]                  chan_s;
  logic [AW-1:0]               samp_s;
  logic [AW+2:0]               reg_idx_s;
  logic                        smp_valid_s;
  logic [G_NCHAN*G_DATA_W-1:0] smp_data_s, rd_flat_s;
  logic [G_DATA_W-1:0]         rd_sel_s;

  assign buf_sel_s = wb_adr_i[AW+5];
  assign chan_s    = wb_adr_i[AW+4:AW+2];
  assign samp_s    = wb_adr_i[AW+1:2];
  assign reg_idx_s = wb_adr_i[AW+4:2];

  // One outstanding request: nothing new is taken while a read is in flight or an ack is showing.
  assign req_s     = wb_cyc_i & wb_stb_i & ~busy_r & ~ack_r;
  assign buf_rd_s  = req_s & buf_sel_s & ~wb_we_i;
  assign reg_wr_s  = req_s & wb_we_i & ~buf_sel_s;
  assign ctrl_wr_s = reg_wr_s & (reg_idx_s == IDX_CTRL) & wb_sel_i[0];
  assign arm_s     = ctrl_wr_s & wb_dat_i[0];
  assign abort_s   = ctrl_wr_s & wb_dat_i[1];
  assign force_s   = ctrl_wr_s & wb_dat_i[2];

  assign wb_ack_o   = ack_r;
  assign wb_dat_o   = dat_r;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = ~ack_r & wb_cyc_i & wb_stb_i;
  assign irq_o      = irq_r;

`ifdef ADC_CAP_OFFSET_SUB_EN
  logic [G_DATA_W-1:0]         offset_r [G_NCHAN];
  logic                        smp_valid_r, smp_trig_r;
  logic [G_NCHAN*G_DATA_W-1:0] smp_data_r;

  // Offset registers and the extra sample stage; the trigger is delayed with the data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp_valid_r <= 1'b0;
      smp_trig_r  <= 1'b0;
      smp_data_r  <= '0;
      for (int c = 0; c < G_NCHAN; c++) offset_r[c] <= '0;
    end else begin
      smp_valid_r <= adc_valid_i;
      smp_trig_r  <= trig_i;
      for (int c = 0; c < G_NCHAN; c++) begin
        smp_data_r[c*G_DATA_W +: G_DATA_W] <= adc_data_i[c*G_DATA_W +: G_DATA_W] - offset_r[c];
        if (reg_wr_s && (reg_idx_s == IDX_OFS0 + (AW+3)'(c)))
          offset_r[c] <= G_DATA_W'(byte_merge(32'(offset_r[c]), wb_dat_i, wb_sel_i));
      end
    end
  end

  // Offset readback.
  always_comb begin
    ofs_rdata_s = 32'd0;
    for (int c = 0; c < G_NCHAN; c++)
      ofs_rdata_s = (reg_idx_s == IDX_OFS0 + (AW+3)'(c)) ? 32'(offset_r[c]) : ofs_rdata_s;
  end

  assign smp_valid_s = smp_valid_r;
  assign smp_data_s  = smp_data_r;
  assign trig_src_s  = smp_trig_r;
`else
  assign ofs_rdata_s = 32'd0;
  assign smp_valid_s = adc_valid_i;
  assign smp_data_s  = adc_data_i;
  assign trig_src_s  = trig_i;
`endif

  assign trig_s  = (trig_src_s & ~trig_prev_r) | force_s;
  assign wr_en_s = smp_valid_s & ((state_r == ST_ARMED) | (state_r == ST_CAPTURE)) & ~abort_s;
  // POSTLEN of zero stands for a full buffer of post-trigger samples.
  assign postlen_eff_s = {(postlen_r == '0), postlen_r};

  for (genvar c = 0; c < G_NCHAN; c++) begin : g_chan
    logic [G_DATA_W-1:0] mem_r [DEPTH];
    logic [G_DATA_W-1:0] rd_q_r;

    // Per-channel sample RAM; a read colliding with a write returns the old word.
    always_ff @(posedge clk_i) begin
      if (wr_en_s) mem_r[wr_ptr_r] <= smp_data_s[c*G_DATA_W +: G_DATA_W];
      if (buf_rd_s) rd_q_r <= mem_r[samp_s];
    end

    assign rd_flat_s[c*G_DATA_W +: G_DATA_W] = rd_q_r;
  end

  // Channel select for buffer readback; absent channels read zero.
  always_comb begin
    rd_sel_s = '0;
    for (int c = 0; c < G_NCHAN; c++)
      rd_sel_s = (rd_chan_r == 3'(c)) ? rd_flat_s[c*G_DATA_W +: G_DATA_W] : rd_sel_s;
  end

  // Register read mux.
  always_comb begin
    reg_rdata_s = 32'd0;
    case (reg_idx_s)
      IDX_VERSION: reg_rdata_s = version_i;
      IDX_STATUS:  reg_rdata_s = {{(16-AW){1'b0}}, trig_ptr_r, 13'd0, wrapped_r, state_r};
      IDX_POSTLEN: reg_rdata_s = {{(32-AW){1'b0}}, postlen_r};
      default:     reg_rdata_s = ofs_rdata_s;
    endcase
  end

  // Capture FSM next state and post-trigger count; ABORT overrides everything.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = post_cnt_r;
    if (abort_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (arm_s) begin
            state_nx_s = ST_ARMED;
            cnt_nx_s   = '0;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_ARMED: begin
          if (trig_s) begin
            cnt_nx_s   = wr_en_s ? (AW+1)'(32'd1) : '0;
            state_nx_s = (wr_en_s && postlen_eff_s == (AW+1)'(32'd1)) ? ST_DONE : ST_CAPTURE;
          end else begin
            state_nx_s = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (wr_en_s) begin
            cnt_nx_s   = post_cnt_r + (AW+1)'(32'd1);
            state_nx_s = (cnt_nx_s == postlen_eff_s) ? ST_DONE : ST_CAPTURE;
          end else begin
            state_nx_s = ST_CAPTURE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Capture state, pointers and the done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      wr_ptr_r    <= '0;
      trig_ptr_r  <= '0;
      wrapped_r   <= 1'b0;
      post_cnt_r  <= '0;
      trig_prev_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      post_cnt_r  <= cnt_nx_s;
      trig_prev_r <= trig_src_s;
      irq_r       <= (state_nx_s == ST_DONE) && (state_r != ST_DONE);
      if (!abort_s && arm_s && (state_r == ST_IDLE || state_r == ST_DONE)) begin
        wr_ptr_r  <= '0;
        wrapped_r <= 1'b0;
      end else if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(32'd1);
        if (state_r == ST_ARMED && wr_ptr_r == PTR_MAX) wrapped_r <= 1'b1;
      end
      if (state_r == ST_ARMED && trig_s && !abort_s) trig_ptr_r <= wr_ptr_r;
    end
  end

  // Wishbone response: registers ack next cycle, buffer reads one cycle later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r     <= 1'b0;
      busy_r    <= 1'b0;
      dat_r     <= 32'd0;
      rd_chan_r <= 3'd0;
      postlen_r <= '0;
    end else begin
      ack_r <= 1'b0;
      if (busy_r) begin
        ack_r  <= 1'b1;
        busy_r <= 1'b0;
        dat_r  <= 32'(rd_sel_s);
      end else if (req_s) begin
        if (buf_rd_s) begin
          busy_r    <= 1'b1;
          rd_chan_r <= chan_s;
        end else begin
          ack_r <= 1'b1;
          dat_r <= wb_we_i ? 32'd0 : reg_rdata_s;
        end
        if (reg_wr_s && reg_idx_s == IDX_POSTLEN)
          postlen_r <= AW'(byte_merge({{(32-AW){1'b0}}, postlen_r}, wb_dat_i, wb_sel_i));
      end
    end
  end
endmodule

// File: doc/adc_capture_csr.md
ADC_CAPTURE_CSR -- requirements
Module: adc_capture_csr

Interface
REQ-001 SHALL have parameter G_NCHAN, default 2, meaning number of ADC channels (1..8).
REQ-002 SHALL have parameter G_DEPTH_LOG2, default 12, meaning log2 of the per-channel buffer depth (4..12).
REQ-003 SHALL have parameter G_DATA_W, default 16, meaning sample width (8..32).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have Wishbone slave ports wb_cyc_i, wb_stb_i, wb_we_i (1 each), wb_adr_i [G_DEPTH_LOG2+5:2], wb_sel_i [3:0], wb_dat_i [31:0], all inputs.
REQ-007 SHALL have Wishbone outputs wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o (1 each) and wb_dat_o [31:0].
REQ-008 SHALL have port version_i, input, 32, the firmware version.
REQ-009 SHALL have port adc_data_i, input, G_NCHAN*G_DATA_W, packed samples; channel c occupies bits [c*G_DATA_W +: G_DATA_W].
REQ-010 SHALL have port adc_valid_i, input, 1, sample strobe.
REQ-011 SHALL have port trig_i, input, 1, external trigger level.
REQ-012 SHALL have port irq_o, input-independent output, 1, one-cycle capture-done pulse.

Function
REQ-013 SHALL decode wb_adr_i MSB=0 as register space and MSB=1 as buffer space; in buffer space, the next 3 bits select the channel and the low G_DEPTH_LOG2 bits select the sample.
REQ-014 SHALL implement these registers:
- 0x00 VERSION (RO) = version_i
- 0x04 CTRL (WO): bit0 ARM, bit1 ABORT, bit2 FORCE_TRIG, all self-clearing
- 0x08 STATUS (RO): [1:0] state, bit2 WRAPPED, [31:16] TRIG_PTR
- 0x0C POSTLEN (RW, G_DEPTH_LOG2 bits); value 0 means 2^G_DEPTH_LOG2 samples
REQ-015 SHALL ack register accesses one cycle after the request, and buffer reads two cycles after the request (registered RAM); wb_stall_o = ~ack & cyc & stb.
REQ-016 SHALL ack buffer writes and writes to RO addresses without effect; unmapped registers and channels >= G_NCHAN read 0; wb_err_o and wb_rty_o are held at 0.
REQ-017 SHALL accept at most one outstanding request; a new request is taken only after the previous ack.
REQ-018 SHALL implement capture FSM states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-019 SHALL move IDLE->ARMED on ARM, and also DONE->ARMED on ARM; ARM in ARMED or CAPTURE is ignored.
REQ-020 In ARMED and CAPTURE, on each adc_valid_i SHALL write all channels at WR_PTR, then increment WR_PTR modulo 2^G_DEPTH_LOG2; wrap-around in ARMED sets WRAPPED.
REQ-021 SHALL go ARMED->CAPTURE on a trig_i rising edge (registered previous value) or on FORCE_TRIG; TRIG_PTR latches the WR_PTR of the sample being written in that cycle, or of the next sample if no valid is present.
REQ-022 In CAPTURE, SHALL count written samples and go to DONE after POSTLEN samples, pulsing irq_o for one cycle on entering DONE.
REQ-023 ABORT SHALL force IDLE from any state without an irq_o pulse; if ABORT and a trigger occur in the same cycle, ABORT wins.
REQ-024 ARM SHALL clear WR_PTR, WRAPPED and the post-trigger counter.
REQ-025 A buffer read during a write to the same address SHALL return the old data.

Reset
REQ-026 On reset, SHALL set state IDLE, WR_PTR 0, TRIG_PTR 0, WRAPPED 0, POSTLEN 0, irq_o 0, wb_ack_o 0 and wb_dat_o 0; buffer contents are not cleared.
REQ-027 Reset asserted mid-capture SHALL abandon the capture with no irq_o pulse, and an in-flight Wishbone access SHALL be dropped without ack.

Configuration
REQ-028 With ADC_CAP_OFFSET_SUB_EN defined, SHALL provide per-channel RW offset registers at 0x20+4*c (G_DATA_W bits, reset 0) and store sample minus offset, modulo 2^G_DATA_W, adding one pipeline stage on the write path (pointer/trigger timing follows the delayed sample).
REQ-029 Without ADC_CAP_OFFSET_SUB_EN, addresses 0x20.. SHALL read 0 with writes acked and ignored, and samples SHALL be stored unmodified.

Verification
REQ-030 Read 0x00 with version_i=0xCAFE0102 -> ack at cycle+1, data 0xCAFE0102.
REQ-031 Set POSTLEN=8, ARM, feed 20 valids, pulse trig_i at sample 12 -> TRIG_PTR=12, DONE after sample 19, irq_o pulses once, STATUS[1:0]=3.
REQ-032 With G_DEPTH_LOG2=4: ARM, feed 18 samples, then FORCE_TRIG -> WRAPPED=1 and WR_PTR wrapped to 2.
REQ-033 Issue ABORT and trig_i rise in the same cycle while ARMED -> state IDLE, no irq_o pulse.
REQ-034 Read channel 1 sample 5 after capturing a ramp whose value is 5 at that sample -> ack at cycle+2, data 5 zero-extended; reading channel 7 with G_NCHAN=2 -> 0.
REQ-035 With ADC_CAP_OFFSET_SUB_EN defined, offset 0x0010 and sample 0x0005 -> stored value 0xFFF5.
